// File: rtl/phys_free_list_pkg.sv
// rtl/phys_free_list_pkg.sv - shared sizing, types and reset contents for the physical register free list
package phys_free_list_pkg;

  localparam int PHYS_W   = 6;
  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int IDX_W    = 5;
  localparam string FL_TAG = "FreeList";

  typedef logic [PHYS_W-1:0] phys_t;
  // index bits plus one wrap bit so full and empty are distinguishable
  typedef logic [IDX_W:0]    ptr_t;

  // Registers 0..NUM_ARCH-1 start out as the architectural mappings; the rest start free.
  function automatic phys_t reset_entry(input int i);
    return phys_t'(NUM_ARCH + i);
  endfunction

endpackage

// File: rtl/phys_free_list.sv
// rtl/phys_free_list.sv - circular free list of physical registers with speculative and committed heads
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              alloc_req,
  output logic [PHYS_W-1:0] alloc_reg,
  output logic              alloc_valid,
  input  logic [PHYS_W-1:0] free_reg,
  input  logic              free_valid,
  input  logic              commit_pop,
  input  logic              flush,
  output logic [PHYS_W-1:0] free_count,
  output logic              overflow_err
);

  phys_t arr [FL_DEPTH];
  ptr_t  head;
  ptr_t  commit_head;
  ptr_t  tail;
  ptr_t  count;
  ptr_t  commit_inc;
  logic  full;
  logic  free_nonzero;
  logic  do_alloc;
  logic  do_push;

  assign count        = tail - head;
  assign full         = (count == ptr_t'(FL_DEPTH));
  assign alloc_valid  = (count != '0);
  assign alloc_reg    = arr[head[IDX_W-1:0]];
  assign free_count   = count;
  assign commit_inc   = {{IDX_W{1'b0}}, commit_pop};
  // phys 0 is permanently bound to arch r0 and must never re-enter the pool
  assign free_nonzero = free_valid && (free_reg != '0);
  // a flush steals the cycle from allocation so the rewound head is not disturbed
  assign do_alloc     = alloc_req && alloc_valid && !stall && !flush;
  assign do_push      = free_nonzero && !full;

  // Pointer and sticky-error state; a flush rewinds the speculative head onto the committed one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      commit_head  <= '0;
      tail         <= ptr_t'(FL_DEPTH);
      overflow_err <= 1'b0;
    end else begin
      commit_head <= commit_head + commit_inc;
      if (flush) begin
        head <= commit_head + commit_inc;
      end else if (do_alloc) begin
        head <= head + ptr_t'(1);
      end
      if (do_push) begin
        tail <= tail + ptr_t'(1);
      end
      if (free_nonzero && full) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Entry storage; written only at the tail, so a pushed register shows up at alloc_reg a cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        arr[i] <= reset_entry(i);
      end
    end else if (do_push) begin
      arr[tail[IDX_W-1:0]] <= free_reg;
    end
  end

`ifdef FREELIST
  // Per-cycle pointer trace for debugging rename stalls
  always @(posedge clk) begin
    $display("%s head=%0d tail=%0d commit_head=%0d count=%0d", FL_TAG, head, tail, commit_head, count);
  end
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// tb/tb_phys_free_list.sv - self-checking bench for phys_free_list
module tb_phys_free_list;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic       alloc_req = 1'b0;
  logic [5:0] alloc_reg;
  logic       alloc_valid;
  logic [5:0] free_reg = '0;
  logic       free_valid = 1'b0;
  logic       commit_pop = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] free_count;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phys_free_list dut (
    .clk(clk), .reset(reset), .stall(stall), .alloc_req(alloc_req),
    .alloc_reg(alloc_reg), .alloc_valid(alloc_valid), .free_reg(free_reg),
    .free_valid(free_valid), .commit_pop(commit_pop), .flush(flush),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  typedef struct {
    logic       stall;
    logic       alloc_req;
    logic       free_valid;
    logic [5:0] free_reg;
    logic       commit_pop;
    logic       flush;
    logic [5:0] exp_reg;
    logic       exp_valid;
    logic [5:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  typedef struct {
    int arch;
    int newp;
    int oldp;
  } inflight_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; alloc_req = 1'b0; free_valid = 1'b0; free_reg = '0;
    commit_pop = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_alloc_reg"}, int'(alloc_reg), 32);
    chk({tag, "_alloc_valid"}, int'(alloc_valid), 1);
    chk({tag, "_free_count"}, int'(free_count), 32);
    chk({tag, "_overflow"}, int'(overflow_err), 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Reference model: the list is a queue starting at the committed head;
  // spec_n entries of it are speculatively allocated.
  int        fq[$];
  int        spec_n;
  inflight_t inflight[$];
  int        spec_map [32];
  int        commit_map [32];

  task automatic model_reset();
    fq.delete();
    inflight.delete();
    for (int i = 0; i < 32; i++) begin
      fq.push_back(32 + i);
      spec_map[i]   = i;
      commit_map[i] = i;
    end
    spec_n = 0;
  endtask

  initial begin
    int cnt;
    int newp;
    int r;
    bit grant;
    bit push;
    inflight_t e;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 6'd32, 1'b1, 6'd32, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 6'd32, 1'b1, 6'd32, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd33, 1'b1, 6'd31, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd33, 1'b1, 6'd31, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd34, 1'b1, 6'd30, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd35, 1'b1, 6'd29, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd35, 1'b1, 6'd29, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd33, 1'b1, 6'd31, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 6'd33, 1'b1, 6'd31, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 6'd34, 1'b1, 6'd30, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 6'd35, 1'b1, 6'd30, 1'b1};

    // reset state
    do_reset();
    check_reset_state("reset");

    // directed vector table: dropped frees, overflow, stall, commit and flush
    for (int i = 0; i < 11; i++) begin
      stall      = vecs[i].stall;
      alloc_req  = vecs[i].alloc_req;
      free_valid = vecs[i].free_valid;
      free_reg   = vecs[i].free_reg;
      commit_pop = vecs[i].commit_pop;
      flush      = vecs[i].flush;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_alloc_reg", i), int'(alloc_reg), int'(vecs[i].exp_reg));
      chk($sformatf("vec%0d_alloc_valid", i), int'(alloc_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_free_count", i), int'(free_count), int'(vecs[i].exp_count));
      chk($sformatf("vec%0d_overflow", i), int'(overflow_err), int'(vecs[i].exp_ovf));
    end
    idle_inputs();

    // drain the full list back-to-back, then an ignored alloc on empty
    do_reset();
    alloc_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("drain%0d_alloc_reg", i), int'(alloc_reg), 32 + i);
      @(posedge clk);
      @(negedge clk);
    end
    chk("drained_valid", int'(alloc_valid), 0);
    chk("drained_count", int'(free_count), 0);
    @(posedge clk);
    @(negedge clk);
    chk("extra_alloc_valid", int'(alloc_valid), 0);
    chk("extra_alloc_count", int'(free_count), 0);

    // free into empty list alongside alloc_req: no bypass, visible next cycle
    free_valid = 1'b1;
    free_reg   = 6'd5;
    #1;
    chk("bypass_valid", int'(alloc_valid), 0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    chk("refill_alloc_reg", int'(alloc_reg), 5);
    chk("refill_valid", int'(alloc_valid), 1);
    chk("refill_count", int'(free_count), 1);

    // randomized rename traffic against the queue model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      cnt = fq.size() - spec_n;
      chk("rnd_valid", int'(alloc_valid), (cnt > 0) ? 1 : 0);
      chk("rnd_count", int'(free_count), cnt);
      chk("rnd_overflow", int'(overflow_err), 0);
      if (cnt > 0) chk("rnd_alloc_reg", int'(alloc_reg), fq[spec_n]);

      stall      = ($urandom_range(3) == 0);
      alloc_req  = ($urandom_range(9) < 6);
      flush      = ($urandom_range(24) == 0);
      commit_pop = (inflight.size() > 0) && ($urandom_range(2) != 0);
      free_valid = 1'b0;
      free_reg   = '0;
      if (commit_pop) begin
        free_valid = 1'b1;
        free_reg   = 6'(inflight[0].oldp);
      end else if ($urandom_range(7) == 0) begin
        free_valid = 1'b1;
      end

      grant = alloc_req && (cnt > 0) && !stall && !flush;
      push  = free_valid && (free_reg != 0) && (cnt < 32);
      newp  = (cnt > 0) ? fq[spec_n] : 0;
      r     = $urandom_range(31, 1);

      @(posedge clk);

      if (commit_pop) begin
        e = inflight.pop_front();
        commit_map[e.arch] = e.newp;
        void'(fq.pop_front());
        spec_n--;
      end
      if (flush) begin
        spec_n = 0;
        inflight.delete();
        spec_map = commit_map;
      end else if (grant) begin
        e.arch = r;
        e.newp = newp;
        e.oldp = spec_map[r];
        spec_map[r] = newp;
        inflight.push_back(e);
        spec_n++;
      end
      if (push) fq.push_back(int'(free_reg));

      @(negedge clk);
    end
    idle_inputs();

    // asynchronous reset in the middle of traffic
    alloc_req = 1'b1;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("post_midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
